// File: rtl/delay.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : delay                                                           |
// | Brief    : Free-running divider; one-clock strobe on out every             |
// |            DELAY_CYCLES mclk cycles. Optional checks: DELAY_PARAM_CHECK_EN |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module delay #(
  parameter int unsigned DELAY_CYCLES = 3_125_000
) (
  input  logic rst,
  input  logic mclk,
  output logic out
);

  // Width never drops below one bit so DELAY_CYCLES = 1 still has a counter.
  localparam int unsigned c_cw = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
  localparam logic [c_cw-1:0] c_last = c_cw'(DELAY_CYCLES - 1);

  logic [c_cw-1:0] cnt;

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      out <= 1'b0;
    end else if (cnt == c_last) begin
      cnt <= '0;
      out <= 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
      out <= 1'b0;
    end
  end

`ifdef DELAY_PARAM_CHECK_EN
  if (DELAY_CYCLES == 0) begin : g_bad_param
    $fatal(1, "%m: DELAY_CYCLES must be at least 1");
  end

  always @(posedge mclk) begin
    if (!rst) begin
      assert (cnt <= c_last)
        else $error("%m: cnt %0d exceeds terminal count %0d", cnt, c_last);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_delay.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_delay                                                        |
// | Brief    : Scoreboard bench for delay at several DELAY_CYCLES settings     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_delay;

  logic mclk = 1'b0;
  logic rst4 = 1'b1, rst1 = 1'b1, rst5 = 1'b1, rstb = 1'b1;
  logic out4, out1, out5, outb;

  int n_cmp = 0;
  int n_bad = 0;
  bit exp_q[$];

  always #5 mclk = ~mclk;

  delay #(4) u4 (.rst(rst4), .mclk(mclk), .out(out4));
  delay #(1) u1 (.rst(rst1), .mclk(mclk), .out(out1));
  delay #(5) u5 (.rst(rst5), .mclk(mclk), .out(out5));
  delay      ub (.rst(rstb), .mclk(mclk), .out(outb));

  // Advance to the next rising edge and settle 1 ns past it.
  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic test_reset();
    bit e;
    repeat (3) tick();
    n_cmp++; if (out4 !== 1'b0) begin n_bad++; $display("FAIL reset_out got %b want 0", out4); end
    n_cmp++; if (u4.cnt !== 2'd0) begin n_bad++; $display("FAIL reset_cnt got %0d want 0", u4.cnt); end
    rst4 = 1'b0;
    repeat (2) tick();
    n_cmp++; if (u4.cnt !== 2'd2) begin n_bad++; $display("FAIL count_2 got %0d want 2", u4.cnt); end
    // assert reset between edges; effect must be visible before the next edge
    #2 rst4 = 1'b1;
    #1;
    n_cmp++; if (u4.cnt !== 2'd0) begin n_bad++; $display("FAIL async_cnt got %0d want 0", u4.cnt); end
    tick();
    rst4 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      exp_q.push_back(k % 4 == 0);
      tick();
      e = exp_q.pop_front();
      n_cmp++; if (out4 !== e) begin n_bad++; $display("FAIL strobe_pre k=%0d got %b want %b", k, out4, e); end
    end
    #2 rst4 = 1'b1;
    #1;
    n_cmp++; if (out4 !== 1'b0) begin n_bad++; $display("FAIL async_out got %b want 0", out4); end
    n_cmp++; if (u4.cnt !== 2'd0) begin n_bad++; $display("FAIL async_cnt2 got %0d want 0", u4.cnt); end
    tick();
  endtask

  task automatic test_period();
    bit e;
    int pulses = 0;
    rst4 = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      exp_q.push_back(k % 4 == 0);
      tick();
      e = exp_q.pop_front();
      if (out4 === 1'b1) pulses++;
      n_cmp++; if (out4 !== e) begin n_bad++; $display("FAIL period k=%0d got %b want %b", k, out4, e); end
    end
    n_cmp++; if (pulses != 5) begin n_bad++; $display("FAIL pulse_count got %0d want 5", pulses); end
  endtask

  task automatic test_unit_divider();
    bit e;
    n_cmp++; if (out1 !== 1'b0) begin n_bad++; $display("FAIL unit_reset got %b want 0", out1); end
    rst1 = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      exp_q.push_back(1'b1);
      tick();
      e = exp_q.pop_front();
      n_cmp++; if (out1 !== e) begin n_bad++; $display("FAIL unit k=%0d got %b want %b", k, out1, e); end
    end
  endtask

  task automatic test_mid_reset();
    bit e;
    rst5 = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      exp_q.push_back(1'b0);
      tick();
      e = exp_q.pop_front();
      n_cmp++; if (out5 !== e) begin n_bad++; $display("FAIL mid_pre k=%0d got %b want %b", k, out5, e); end
    end
    n_cmp++; if (u5.cnt !== 3'd3) begin n_bad++; $display("FAIL mid_cnt got %0d want 3", u5.cnt); end
    rst5 = 1'b1;
    tick();
    rst5 = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      exp_q.push_back(k % 5 == 0);
      tick();
      e = exp_q.pop_front();
      n_cmp++; if (out5 !== e) begin n_bad++; $display("FAIL mid_post k=%0d got %b want %b", k, out5, e); end
    end
  endtask

  task automatic test_large();
    bit e;
    n_cmp++; if ($bits(ub.cnt) != 22) begin n_bad++; $display("FAIL width got %0d want 22", $bits(ub.cnt)); end
    rstb = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      exp_q.push_back(1'b0);
      tick();
      e = exp_q.pop_front();
      n_cmp++; if (outb !== e) begin n_bad++; $display("FAIL large k=%0d got %b want %b", k, outb, e); end
    end
    n_cmp++; if (ub.cnt !== 22'd40) begin n_bad++; $display("FAIL large_cnt got %0d want 40", ub.cnt); end
  endtask

  initial begin
    test_reset();
    test_period();
    test_unit_divider();
    test_mid_reset();
    test_large();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
